// File: rtl/pll_mon_pkg.sv
// pll_mon_pkg: shared types and defaults for the PLL lock monitor.
// Optional feature macro: PLL_MON_AUTORETRY_EN (WAIT timeout + PLL retry).
package pll_mon_pkg;

  typedef enum logic [1:0] {
    ST_PLLRST = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STABLE = 2'd2,
    ST_RUN    = 2'd3
  } pll_state_e;

  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_LOCK_TIMEOUT  = 500000;
  localparam int DEF_RST_PULSE     = 16;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_mon_sync.sv
// pll_mon_sync: two-flop synchronizer for the asynchronous PLL lock flag.
// Optional feature macro: PLL_MON_AUTORETRY_EN (not used here).
module pll_mon_sync
  import pll_mon_pkg::*;
(
  input  logic refclk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; both flops clear on reset.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: PLL reset sequencer, lock qualifier and loss counters.
// Optional feature macro: PLL_MON_AUTORETRY_EN (WAIT timeout + PLL retry).
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int RST_PULSE     = DEF_RST_PULSE
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [7:0] lost_cnt,
  output logic [7:0] retry_cnt,
  output logic [1:0] state
);

  localparam int TMAX = max3(STABLE_CYCLES, LOCK_TIMEOUT, RST_PULSE);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(RST_PULSE - 1);
  localparam logic [TW-1:0] STAB_LAST  = TW'(STABLE_CYCLES - 1);
`ifdef PLL_MON_AUTORETRY_EN
  localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
`endif

  pll_state_e    r_state;
  pll_state_e    w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [7:0]    r_lost;
  logic          w_lost_inc;
  logic          r_pll_rst;
  logic          r_sys_rst_n;
  logic          w_locked_s;
`ifdef PLL_MON_AUTORETRY_EN
  logic [7:0]    r_retry;
  logic          w_retry_inc;
`endif

  pll_mon_sync u_sync (
    .refclk  (refclk),
    .rst_n   (rst_n),
    .i_async (locked),
    .o_sync  (w_locked_s)
  );

  // Next-state and shared timer; timer always restarts at 0 on a state change.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_lost_inc  = 1'b0;
`ifdef PLL_MON_AUTORETRY_EN
    w_retry_inc = 1'b0;
`endif
    unique case (r_state)
      ST_PLLRST: begin
        if (r_timer == PULSE_LAST) begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      ST_WAIT: begin
        if (w_locked_s) begin
          w_state_nxt = ST_STABLE;
          w_timer_nxt = '0;
        end
`ifdef PLL_MON_AUTORETRY_EN
        else if (r_timer == TO_LAST) begin
          w_state_nxt = ST_PLLRST;
          w_timer_nxt = '0;
          w_retry_inc = 1'b1;
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
`endif
      end
      ST_STABLE: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = '0;
        end else if (r_timer == STAB_LAST) begin
          w_state_nxt = ST_RUN;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + T_ONE;
        end
      end
      ST_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = '0;
          w_lost_inc  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_PLLRST;
        w_timer_nxt = '0;
      end
    endcase
  end

  // State, timer, loss counter and registered reset outputs.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state     <= ST_PLLRST;
      r_timer     <= '0;
      r_lost      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_pll_rst   <= (w_state_nxt == ST_PLLRST);
      r_sys_rst_n <= (w_state_nxt == ST_RUN);
      if (w_lost_inc) begin
        r_lost <= sat_inc(r_lost);
      end
    end
  end

`ifdef PLL_MON_AUTORETRY_EN
  // Saturating count of WAIT timeouts that re-pulsed the PLL.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_retry <= '0;
    end else if (w_retry_inc) begin
      r_retry <= sat_inc(r_retry);
    end
  end

  assign retry_cnt = r_retry;
`else
  assign retry_cnt = 8'd0;
`endif

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign lost_cnt  = r_lost;
  assign state     = r_state;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: directed table, corner sequences, random vs model.
// Optional feature macro: PLL_MON_AUTORETRY_EN (selects retry expectations).
module tb_pll_lock_monitor;

  localparam int SC = 8;
  localparam int LT = 100;
  localparam int RP = 4;
`ifdef PLL_MON_AUTORETRY_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic [7:0] lost_cnt;
  logic [7:0] retry_cnt;
  logic [1:0] state;

  pll_lock_monitor #(
    .STABLE_CYCLES (SC),
    .LOCK_TIMEOUT  (LT),
    .RST_PULSE     (RP)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .lost_cnt  (lost_cnt),
    .retry_cnt (retry_cnt),
    .state     (state)
  );

  always #5 refclk = ~refclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: phase + elapsed count, lock seen through a 2-deep queue.
  int m_mode;
  int m_cnt;
  int m_lost;
  int m_retry;
  bit m_q[$];

  task automatic model_reset();
    m_mode  = 0;
    m_cnt   = 0;
    m_lost  = 0;
    m_retry = 0;
    m_q     = {1'b0, 1'b0};
  endtask

  task automatic model_step(input bit lk);
    bit ls;
    ls = m_q.pop_front();
    m_q.push_back(lk);
    case (m_mode)
      0: begin
        m_cnt++;
        if (m_cnt == RP) begin
          m_mode = 1;
          m_cnt  = 0;
        end
      end
      1: begin
        if (ls) begin
          m_mode = 2;
          m_cnt  = 0;
        end else if (AR) begin
          m_cnt++;
          if (m_cnt == LT) begin
            m_mode  = 0;
            m_cnt   = 0;
            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
          end
        end
      end
      2: begin
        if (!ls) begin
          m_mode = 1;
          m_cnt  = 0;
        end else begin
          m_cnt++;
          if (m_cnt == SC) begin
            m_mode = 3;
            m_cnt  = 0;
          end
        end
      end
      default: begin
        if (!ls) begin
          m_mode = 1;
          m_cnt  = 0;
          m_lost = (m_lost < 255) ? m_lost + 1 : 255;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive, step the model at the edge, compare at the negedge.
  task automatic cyc(input bit lk, input bit rn);
    logic [19:0] got;
    logic [19:0] exp;
    locked = lk;
    rst_n  = rn;
    @(posedge refclk);
    if (!rn) model_reset();
    else     model_step(lk);
    @(negedge refclk);
    got = {state, pll_rst, sys_rst_n, lost_cnt, retry_cnt};
    exp = {2'(m_mode), (m_mode == 0), (m_mode == 3),
           8'(m_lost), 8'(m_retry)};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL model t=%0t got st=%0d pll=%b sys=%b lost=%0d retry=%0d expected st=%0d pll=%b sys=%b lost=%0d retry=%0d",
               $time, state, pll_rst, sys_rst_n, lost_cnt, retry_cnt,
               exp[19:18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  typedef struct {
    bit       lk;
    bit       rn;
    int       st;
    bit       pll;
    bit       sys;
    int       lost;
  } vec_t;

  vec_t tbl[20];

  initial begin : main
    int rises;
    int prev;
    int t_stb;
    int t_run;
    int hi;
    bit seen_wait;

    for (int i = 0; i < 20; i++) tbl[i] = '{1'b1, 1'b1, 2, 1'b0, 1'b0, 0};
    tbl[0]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b1, 1, 1'b0, 1'b0, 0};
    tbl[15] = '{1'b1, 1'b1, 3, 1'b0, 1'b1, 0};
    tbl[16] = '{1'b0, 1'b1, 3, 1'b0, 1'b1, 0};
    tbl[17] = '{1'b1, 1'b1, 3, 1'b0, 1'b1, 0};
    tbl[18] = '{1'b1, 1'b1, 1, 1'b0, 1'b0, 1};
    tbl[19] = '{1'b1, 1'b1, 2, 1'b0, 1'b0, 1};

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].lk, tbl[i].rn);
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_pll", i), pll_rst, tbl[i].pll);
      chk($sformatf("tbl%0d_sys", i), sys_rst_n, tbl[i].sys);
      chk($sformatf("tbl%0d_lost", i), lost_cnt, tbl[i].lost);
    end

    // Never locks: periodic retries (or none without autoretry).
    cyc(1'b0, 1'b0);
    rises = 0;
    prev  = pll_rst;
    for (int i = 1; i <= 1000; i++) begin
      cyc(1'b0, 1'b1);
      if (pll_rst && prev == 0) rises++;
      prev = pll_rst;
      if (i == 410) begin
        chk("retry_410", retry_cnt, AR ? 3 : 0);
        chk("pulses_410", rises, AR ? 3 : 0);
      end
    end
    chk("retry_1000", retry_cnt, AR ? 9 : 0);
    chk("pulses_1000", rises, AR ? 9 : 0);
    chk("sys_unlocked", sys_rst_n, 0);

    // Glitch in the fifth STABLE cycle restarts qualification.
    cyc(1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b1);
    repeat (7) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    seen_wait = 1'b0;
    t_stb = -1;
    t_run = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b1);
      if (state == 2'd1) seen_wait = 1'b1;
      if (seen_wait && state == 2'd2 && t_stb < 0) t_stb = i;
      if (state == 2'd3 && t_run < 0) t_run = i;
    end
    chk("glitch_wait", seen_wait, 1);
    chk("glitch_requal", t_run - t_stb, SC);
    chk("glitch_lost", lost_cnt, 0);

    // 300 lock losses saturate the loss counter.
    repeat (300) begin
      cyc(1'b0, 1'b1);
      repeat (14) cyc(1'b1, 1'b1);
    end
    chk("lost_sat", lost_cnt, 255);
    chk("lost_state", state, 3);

    // Reset in RUN takes effect at once and replays the full pulse.
    cyc(1'b1, 1'b0);
    chk("rst_pll", pll_rst, 1);
    chk("rst_sys", sys_rst_n, 0);
    chk("rst_lost", lost_cnt, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_state", state, 0);
    hi = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1);
      if (pll_rst) hi++;
    end
    chk("pulse_len", hi, RP);

    // Random lock waveform with occasional resets.
    cyc(1'b0, 1'b0);
    for (int s = 0; s < 400; s++) begin
      bit lk;
      int len;
      lk  = $urandom_range(0, 1) != 0;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(90, 160)
                                        : $urandom_range(1, 20);
      if ($urandom_range(0, 60) == 0) cyc(lk, 1'b0);
      repeat (len) cyc(lk, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset release.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 500000: maximum cycles in WAIT before a PLL retry (10 ms at 50 MHz).
REQ-003 SHALL have parameter RST_PULSE, default 16: pll_rst pulse length in cycles.
REQ-004 SHALL have port refclk, input, 1: the only clock, the free-running PLL reference.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port locked, input, 1: PLL lock indication, asynchronous to refclk.
REQ-007 SHALL have port pll_rst, output, 1: active-high reset to the PLL.
REQ-008 SHALL have port sys_rst_n, output, 1: active-low reset to downstream logic.
REQ-009 SHALL have port lost_cnt, output, 8: saturating count of lock losses seen in RUN.
REQ-010 SHALL have port retry_cnt, output, 8: saturating count of timeout retries.
REQ-011 SHALL have port state, output, 2: current FSM state code.

Function
REQ-012 SHALL synchronize locked through 2 flops; all decisions use locked_s, 2 cycles behind locked.
REQ-013 SHALL implement states PLLRST=0, WAIT=1, STABLE=2, RUN=3.
REQ-014 PLLRST SHALL hold pll_rst=1 for exactly RST_PULSE cycles, then go to WAIT with the timer cleared.
REQ-015 WAIT SHALL go to STABLE on the first cycle locked_s=1, clearing the timer.
REQ-016 WAIT SHALL go to PLLRST when the timer reaches LOCK_TIMEOUT-1 with locked_s=0, and SHALL increment retry_cnt (saturating at 255).
REQ-017 STABLE SHALL go to RUN after STABLE_CYCLES consecutive cycles of locked_s=1.
REQ-018 STABLE SHALL return to WAIT with the timer cleared on any cycle locked_s=0.
REQ-019 In RUN, locked_s=0 SHALL cause a transition to WAIT and increment lost_cnt (saturating at 255).
REQ-020 sys_rst_n SHALL be a registered output equal to 1 only while state is RUN; it drops on the cycle after locked_s falls.
REQ-021 pll_rst SHALL be a registered output equal to 1 only while in PLLRST.
REQ-022 If timeout and locked_s=1 occur in the same cycle, STABLE SHALL win.
REQ-023 The timer SHALL be sized $clog2 of the largest parameter and SHALL never wrap.

Reset
REQ-024 With rst_n=0 at a refclk edge: state=PLLRST, pll_rst=1, sys_rst_n=0, lost_cnt=0, retry_cnt=0, timer=0, synchronizer flops=0.
REQ-025 Reset asserted mid-operation, including in RUN, SHALL take effect on the next edge and restart the full RST_PULSE sequence after release.

Configuration
REQ-026 With PLL_MON_AUTORETRY_EN defined, the WAIT timeout and retry behaviour of REQ-016 SHALL be present.
REQ-027 Without PLL_MON_AUTORETRY_EN, WAIT SHALL wait indefinitely, and the timeout counter logic SHALL be absent. retry_cnt SHALL then be tied to 0, and pll_rst SHALL assert only after rst_n.

Structure
REQ-028 Package pll_mon_pkg SHALL hold the state enum and the default values of the three parameters.
REQ-029 The 2-flop synchronizer SHALL be the sub-module pll_mon_sync; the FSM, counters and output registers SHALL stay in pll_lock_monitor.

Verification (STABLE_CYCLES=8, LOCK_TIMEOUT=100, RST_PULSE=4, AUTORETRY on)
REQ-030 Release rst_n, then raise locked at cycle 10 -> pll_rst high for cycles 1-4; sys_rst_n rises at 10+2+8+1 (±1 per the documented register stage); state=3.
REQ-031 Keep locked=0 -> pll_rst re-pulses 4 cycles every 104 cycles; retry_cnt=1, 2, 3; sys_rst_n stays 0.
REQ-032 In RUN, drop locked for 1 cycle -> sys_rst_n=0 three cycles later; lost_cnt=1; relock gives sys_rst_n=1 after another 8+ cycles.
REQ-033 Glitch locked low at cycle 5 of STABLE -> return to WAIT; the STABLE count restarts; no lost_cnt increment.
REQ-034 Force 300 lock losses -> lost_cnt=255 and does not wrap.
REQ-035 Assert rst_n=0 during RUN -> next edge sys_rst_n=0, pll_rst=1, counters 0; rebuild with AUTORETRY off -> no retries after 1000 unlocked cycles.
